// File: rtl/stage_sequencer.sv
`timescale 1ns/1ps
// stage_sequencer: multi-cycle stage controller and program counter owner
// for the 8-bit single-issue processor. Stalls MEM on the data-memory
// handshake, aborts on MEM timeout, counts retired instructions.
module stage_sequencer #(
  parameter logic [7:0] START_PC    = 8'd0,
  parameter logic [7:0] MAX_PC      = 8'd16,
  parameter int unsigned MEM_TIMEOUT = 8
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       halt,
  input  logic [7:0] new_pc,
  input  logic       mem_req,
  input  logic       mem_ready,
  output logic [2:0] state,
  output logic [7:0] pc,
  output logic       if_en,
  output logic       id_en,
  output logic       rr_en,
  output logic       ex_en,
  output logic       mem_en,
  output logic       wb_en,
  output logic       out_en,
  output logic       wb_sel,
  output logic       busy,
  output logic       done,
  output logic       error,
  output logic [7:0] instr_count
);

  localparam int unsigned PC_W  = 8;
  localparam int unsigned CNT_W = 8;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_RR   = 3'd2,
    S_EX   = 3'd3,
    S_MEM  = 3'd4,
    S_WB   = 3'd5,
    S_OUT  = 3'd6,
    S_IDLE = 3'd7
  } state_t;

  state_t            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic              wb_sel_q, wb_sel_d;
  logic              done_q, done_d;
  logic              error_q, error_d;
  logic              halt_pend_q, halt_pend_d;
  logic [CNT_W-1:0]  wait_cnt_q, wait_cnt_d;
  logic [CNT_W-1:0]  instr_count_q, instr_count_d;

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= S_IDLE;
      pc_q          <= START_PC;
      wb_sel_q      <= 1'b0;
      done_q        <= 1'b0;
      error_q       <= 1'b0;
      halt_pend_q   <= 1'b0;
      wait_cnt_q    <= '0;
      instr_count_q <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      wb_sel_q      <= wb_sel_d;
      done_q        <= done_d;
      error_q       <= error_d;
      halt_pend_q   <= halt_pend_d;
      wait_cnt_q    <= wait_cnt_d;
      instr_count_q <= instr_count_d;
    end
  end

  // Next-state and register-update logic
  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    wb_sel_d      = wb_sel_q;
    done_d        = done_q;
    error_d       = error_q;
    halt_pend_d   = halt_pend_q;
    wait_cnt_d    = wait_cnt_q;
    instr_count_d = instr_count_q;

    // A halt request is remembered; the running instruction still retires.
    if (halt && (state_q != S_IDLE) && (state_q != S_OUT)) begin
      halt_pend_d = 1'b1;
    end

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          pc_d          = START_PC;
          done_d        = 1'b0;
          error_d       = 1'b0;
          instr_count_d = '0;
          halt_pend_d   = 1'b0;
          state_d       = S_IF;
        end
      end
      S_IF: state_d = S_ID;
      S_ID: state_d = S_RR;
      S_RR: state_d = S_EX;
      S_EX: begin
        wait_cnt_d = '0;
        state_d    = S_MEM;
      end
      S_MEM: begin
        // Completion beats a timeout landing on the same cycle.
        if (!mem_req || mem_ready) begin
          pc_d     = new_pc;
          wb_sel_d = mem_req;
          state_d  = S_WB;
        end else begin
          wait_cnt_d = wait_cnt_q + CNT_W'(1);
          if (wait_cnt_q == CNT_W'(MEM_TIMEOUT - 1)) begin
            error_d = 1'b1;
            done_d  = 1'b1;
            state_d = S_OUT;
          end
        end
      end
      S_WB: begin
        if (instr_count_q != {CNT_W{1'b1}}) begin
          instr_count_d = instr_count_q + CNT_W'(1);
        end
        if (halt_pend_q || (pc_q >= MAX_PC)) begin
          done_d  = 1'b1;
          state_d = S_OUT;
        end else begin
          state_d = S_IF;
        end
      end
      S_OUT: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Output mapping and one-hot stage decode
  always_comb begin
    state       = state_q;
    pc          = pc_q;
    wb_sel      = wb_sel_q;
    done        = done_q;
    error       = error_q;
    instr_count = instr_count_q;
    busy        = (state_q != S_IDLE);
    if_en       = (state_q == S_IF);
    id_en       = (state_q == S_ID);
    rr_en       = (state_q == S_RR);
    ex_en       = (state_q == S_EX);
    mem_en      = (state_q == S_MEM);
    wb_en       = (state_q == S_WB);
    out_en      = (state_q == S_OUT);
  end

endmodule

// File: tb/tb_stage_sequencer.sv
`timescale 1ns/1ps
// Self-checking bench for stage_sequencer: behavioural model, directed
// pinned scenarios and randomized traffic.
module tb_stage_sequencer;

  localparam logic [7:0] START_PC = 8'd0;
  localparam logic [7:0] MAX_PC   = 8'd3;
  localparam int unsigned TMO     = 8;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       halt = 1'b0;
  logic [7:0] new_pc = 8'd0;
  logic       mem_req = 1'b0;
  logic       mem_ready = 1'b0;
  logic [2:0] state;
  logic [7:0] pc;
  logic       if_en, id_en, rr_en, ex_en, mem_en, wb_en, out_en;
  logic       wb_sel, busy, done, error;
  logic [7:0] instr_count;

  int checks = 0;
  int failures = 0;

  stage_sequencer #(
    .START_PC(START_PC), .MAX_PC(MAX_PC), .MEM_TIMEOUT(TMO)
  ) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .halt(halt),
    .new_pc(new_pc), .mem_req(mem_req), .mem_ready(mem_ready),
    .state(state), .pc(pc),
    .if_en(if_en), .id_en(id_en), .rr_en(rr_en), .ex_en(ex_en),
    .mem_en(mem_en), .wb_en(wb_en), .out_en(out_en),
    .wb_sel(wb_sel), .busy(busy), .done(done), .error(error),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Stage numbers: 0..5 = IF..WB, 6 = OUT, 7 = IDLE.
  int       m_state;
  logic [7:0] m_pc;
  bit       m_wb, m_done, m_err, m_hp, hp_was;
  int       m_lows;
  int       m_cnt;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state = 7; m_pc = START_PC; m_wb = 0; m_done = 0; m_err = 0;
      m_hp = 0; m_lows = 0; m_cnt = 0;
    end else begin
      hp_was = m_hp;
      if (halt && m_state <= 5) m_hp = 1;
      if (m_state == 7) begin
        if (start) begin
          m_pc = START_PC; m_done = 0; m_err = 0; m_cnt = 0; m_hp = 0;
          m_state = 0;
        end
      end else if (m_state < 3) begin
        m_state = m_state + 1;
      end else if (m_state == 3) begin
        m_lows = 0;
        m_state = 4;
      end else if (m_state == 4) begin
        if (!mem_req || mem_ready) begin
          m_pc = new_pc; m_wb = mem_req; m_state = 5;
        end else begin
          m_lows = m_lows + 1;
          if (m_lows >= TMO) begin
            m_err = 1; m_done = 1; m_state = 6;
          end
        end
      end else if (m_state == 5) begin
        m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        if (hp_was || m_pc >= MAX_PC) begin
          m_done = 1; m_state = 6;
        end else begin
          m_state = 0;
        end
      end else begin
        m_state = 7;
      end
    end
  end

  // Per-cycle comparison of every output against the model
  always @(negedge clk) begin
    chk("state", state, m_state);
    chk("pc", pc, m_pc);
    chk("wb_sel", wb_sel, m_wb);
    chk("done", done, m_done);
    chk("error", error, m_err);
    chk("instr_count", instr_count, m_cnt);
    chk("busy", busy, m_state != 7);
    chk("enables", {if_en, id_en, rr_en, ex_en, mem_en, wb_en, out_en},
        (m_state <= 6) ? (1 << (6 - m_state)) : 0);
  end

  // ---------------- stimulus driver ----------------
  bit         cfg_start_rand = 0, cfg_halt_rand = 0;
  bit         start_req = 0, halt_req = 0;
  int         cfg_req = 0;      // 0 none, 1 always, 2 random, 3 only off START_PC
  int         cfg_delay = 0;    // <0 random 0..10
  int         cfg_pc_mode = 1;  // 0 random 0..5, 1 pc+1, 2 fixed
  logic [7:0] cfg_pc_val = 8'd0;
  bit         cur_req;
  int         cur_delay, mem_cnt;
  logic [7:0] cur_npc;

  always @(negedge clk) begin
    start = cfg_start_rand ? ($urandom_range(0, 3) == 0) : start_req;
    halt  = cfg_halt_rand ? ($urandom_range(0, 40) == 0) : halt_req;
    if (m_state == 3) begin
      case (cfg_req)
        0: cur_req = 0;
        1: cur_req = 1;
        2: cur_req = 1'($urandom_range(0, 1));
        default: cur_req = (m_pc != START_PC);
      endcase
      cur_delay = (cfg_delay < 0) ? int'($urandom_range(0, 10)) : cfg_delay;
      case (cfg_pc_mode)
        0: cur_npc = 8'($urandom_range(0, 5));
        1: cur_npc = 8'(m_pc + 8'd1);
        default: cur_npc = cfg_pc_val;
      endcase
      mem_cnt = 0;
    end
    if (m_state == 4) begin
      mem_req   = cur_req;
      mem_ready = (mem_cnt >= cur_delay);
      new_pc    = cur_npc;
      mem_cnt++;
    end else begin
      mem_req   = 1'($urandom_range(0, 1));
      mem_ready = 1'($urandom_range(0, 1));
      new_pc    = 8'($urandom);
    end
  end

  // ---------------- sequencing helpers ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Returns just after edge 0, the edge that samples start.
  task automatic kick();
    start_req = 1;
    step(1);
    start_req = 0;
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (state != 3'd7 && n < 3000) begin
      step(1);
      n++;
    end
    chk("idle_wait", state, 7);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 0;
    step(3);
    chk("pin_rst_state", state, 7);
    chk("pin_rst_pc", pc, 0);
    chk("pin_rst_flags", {wb_sel, done, error, busy}, 0);
    chk("pin_rst_en", {if_en, id_en, rr_en, ex_en, mem_en, wb_en, out_en}, 0);
    rst_n = 1;
    step(1);

    // Three straight-line instructions, pc+1 each, no memory access
    cfg_req = 0; cfg_pc_mode = 1; cfg_delay = 0;
    kick();
    chk("pin_p3_e0_state", state, 0);
    step(5);
    chk("pin_p3_e5_state", state, 5);
    chk("pin_p3_e5_pc", pc, 1);
    step(12);
    chk("pin_p3_e17_state", state, 5);
    chk("pin_p3_e17_pc", pc, 3);
    step(1);
    chk("pin_p3_e18_out", {out_en, done}, 3);
    chk("pin_p3_e18_cnt", instr_count, 3);
    step(1);
    chk("pin_p3_e19_state", state, 7);
    chk("pin_p3_e19_done", done, 1);

    // Memory access with ready three cycles late
    wait_idle();
    cfg_req = 1; cfg_delay = 3; cfg_pc_mode = 2; cfg_pc_val = 8'd200;
    kick();
    step(4);
    chk("pin_mem_e4_en", mem_en, 1);
    step(3);
    chk("pin_mem_e7_state", state, 4);
    step(1);
    chk("pin_mem_e8_state", state, 5);
    chk("pin_mem_e8_wbsel", wb_sel, 1);
    chk("pin_mem_e8_pc", pc, 200);
    step(1);
    chk("pin_mem_e9_state", state, 6);
    chk("pin_mem_e9_cnt", instr_count, 1);

    // MEM timeout: ready never arrives
    wait_idle();
    cfg_delay = 255;
    kick();
    step(11);
    chk("pin_tmo_e11_state", state, 4);
    step(1);
    chk("pin_tmo_e12_state", state, 6);
    chk("pin_tmo_e12_flags", {error, done}, 3);
    chk("pin_tmo_e12_pc", pc, 0);
    chk("pin_tmo_e12_cnt", instr_count, 0);
    step(1);
    chk("pin_tmo_e13_state", state, 7);
    chk("pin_tmo_e13_err", error, 1);

    // Halt during EX of instruction 2
    wait_idle();
    cfg_req = 0; cfg_delay = 0; cfg_pc_val = 8'd1;
    kick();
    step(9);
    chk("pin_halt_e9_state", state, 3);
    halt_req = 1;
    step(1);
    halt_req = 0;
    step(1);
    chk("pin_halt_e11_state", state, 5);
    step(1);
    chk("pin_halt_e12_state", state, 6);
    chk("pin_halt_e12_cnt", instr_count, 2);
    chk("pin_halt_e12_err", error, 0);

    // Jump beyond MAX_PC ends after first WB
    wait_idle();
    cfg_pc_val = 8'd200;
    kick();
    step(6);
    chk("pin_far_e6_state", state, 6);
    chk("pin_far_e6_cnt", instr_count, 1);

    // Endless loop saturates the retire counter
    wait_idle();
    cfg_pc_val = START_PC;
    kick();
    step(6 * 260);
    chk("pin_sat_cnt", instr_count, 255);
    chk("pin_sat_busy", busy, 1);
    halt_req = 1;
    step(1);
    halt_req = 0;
    wait_idle();
    chk("pin_sat_done", done, 1);
    chk("pin_sat_cnt_end", instr_count, 255);

    // Reset while stalled in MEM of the second instruction
    cfg_req = 3; cfg_delay = 255; cfg_pc_val = 8'd1;
    kick();
    step(12);
    chk("pin_rstm_state", state, 4);
    chk("pin_rstm_pc", pc, 1);
    chk("pin_rstm_cnt", instr_count, 1);
    start_req = 1;
    rst_n = 0;
    #1;
    chk("pin_rstm_state0", state, 7);
    chk("pin_rstm_pc0", pc, 0);
    chk("pin_rstm_cnt0", instr_count, 0);
    chk("pin_rstm_flags0", {wb_sel, done, error, busy, mem_en}, 0);
    step(1);
    cfg_req = 0; cfg_delay = 0; cfg_pc_val = 8'd200;
    rst_n = 1;
    step(1);
    start_req = 0;
    chk("pin_rstm_restart", state, 0);
    chk("pin_rstm_restart_pc", pc, 0);
    wait_idle();

    // Randomized traffic with occasional asynchronous resets
    cfg_start_rand = 1; cfg_halt_rand = 1;
    cfg_req = 2; cfg_delay = -1; cfg_pc_mode = 0;
    for (int i = 0; i < 3000; i++) begin
      step(1);
      if ($urandom_range(0, 700) == 0) begin
        #1 rst_n = 0;
        step(2);
        rst_n = 1;
      end
    end
    cfg_start_rand = 0; cfg_halt_rand = 0;
    cfg_pc_mode = 2; cfg_pc_val = 8'd200; cfg_delay = 0;
    wait_idle();
    step(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
